// File: rtl/alu.sv
// ----------------------------------------------------------------------------
// alu : registered integer ALU
//
// Two unsigned WIDTH-bit operands are combined according to a 3-bit opcode.
// The 2*WIDTH-bit result is registered and appears one clock after an
// in_valid cycle. There is no backpressure, so a new operation may be issued
// every cycle. Division is fully combinational and completes within the cycle.
//
// Opcodes: 0 ADD, 1 SUB (mod 2**(2*WIDTH)), 2 MUL, 3 DIV ({rem, quot}),
//          4 AND, 5 OR, 6 XOR, 7 NOT A.
//
// Optional build macro: ALU_FLAGS_EN adds the registered flag outputs
// zero, carry and neg. When it is undefined those ports do not exist.
//
// Ports:
//   clk        in   1          rising-edge clock
//   rst_n      in   1          synchronous active-low reset
//   A, B       in   WIDTH      unsigned operands
//   OpCode     in   3          operation select
//   in_valid   in   1          operands/opcode valid this cycle
//   Result     out  2*WIDTH    registered result (holds when in_valid=0)
//   out_valid  out  1          Result came from an in_valid cycle
//   div_zero   out  1          DIV issued with B==0 (holds when in_valid=0)
//   zero       out  1          (ALU_FLAGS_EN) result equals 0
//   carry      out  1          (ALU_FLAGS_EN) ADD WIDTH-bit overflow / SUB borrow
//   neg        out  1          (ALU_FLAGS_EN) result MSB
// ----------------------------------------------------------------------------
module alu #(
   parameter int WIDTH = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [WIDTH-1:0]   A,
   input  logic [WIDTH-1:0]   B,
   input  logic [2:0]         OpCode,
   input  logic               in_valid,
   output logic [2*WIDTH-1:0] Result,
   output logic               out_valid,
`ifdef ALU_FLAGS_EN
   output logic               zero,
   output logic               carry,
   output logic               neg,
`endif
   output logic               div_zero
);

   localparam int RW = 2 * WIDTH;

   typedef enum logic [2:0] {
      OP_ADD = 3'd0,
      OP_SUB = 3'd1,
      OP_MUL = 3'd2,
      OP_DIV = 3'd3,
      OP_AND = 3'd4,
      OP_OR  = 3'd5,
      OP_XOR = 3'd6,
      OP_NOT = 3'd7
   } op_t;

   logic [RW-1:0] a_ext_p0;
   logic [RW-1:0] b_ext_p0;
   logic [RW-1:0] sum_p0;
   logic [RW-1:0] result_p0;
   logic          dz_p0;

   assign a_ext_p0 = {{WIDTH{1'b0}}, A};
   assign b_ext_p0 = {{WIDTH{1'b0}}, B};
   assign sum_p0   = a_ext_p0 + b_ext_p0;

   // ---- p0: combinational operation select ----
   always_comb begin
      result_p0 = '0;
      dz_p0     = 1'b0;
      case (op_t'(OpCode))
         OP_ADD: result_p0 = sum_p0;
         OP_SUB: result_p0 = a_ext_p0 - b_ext_p0;
         OP_MUL: result_p0 = a_ext_p0 * b_ext_p0;
         OP_DIV: begin
            if (B == '0) begin
               result_p0 = '1;
               dz_p0     = 1'b1;
            end else begin
               // remainder in the upper half, quotient in the lower half
               result_p0 = {A % B, A / B};
            end
         end
         OP_AND: result_p0 = a_ext_p0 & b_ext_p0;
         OP_OR:  result_p0 = a_ext_p0 | b_ext_p0;
         OP_XOR: result_p0 = a_ext_p0 ^ b_ext_p0;
         OP_NOT: result_p0 = {{WIDTH{1'b0}}, ~A};
         default: result_p0 = '0;
      endcase
   end

`ifdef ALU_FLAGS_EN
   logic carry_p0;

   // carry is the WIDTH-bit overflow of ADD or the borrow of SUB only
   always_comb begin
      carry_p0 = 1'b0;
      if (op_t'(OpCode) == OP_ADD)
         carry_p0 = |sum_p0[RW-1:WIDTH];
      else if (op_t'(OpCode) == OP_SUB)
         carry_p0 = (A < B);
   end
`endif

   // ---- p0 -> output register ----
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         Result    <= '0;
         out_valid <= 1'b0;
         div_zero  <= 1'b0;
`ifdef ALU_FLAGS_EN
         zero      <= 1'b0;
         carry     <= 1'b0;
         neg       <= 1'b0;
`endif
      end else begin
         out_valid <= in_valid;
         if (in_valid) begin
            Result   <= result_p0;
            div_zero <= dz_p0;
`ifdef ALU_FLAGS_EN
            zero     <= (result_p0 == '0);
            carry    <= carry_p0;
            neg      <= result_p0[RW-1];
`endif
         end
      end
   end

endmodule

// File: tb/tb_alu.sv
// ----------------------------------------------------------------------------
// tb_alu : self-checking bench for alu (WIDTH = 4)
//
// Directed vectors followed by randomized operations, each compared against a
// behavioural model computed with plain integer arithmetic. Flag outputs are
// checked when the bench is built with ALU_FLAGS_EN.
// ----------------------------------------------------------------------------
module tb_alu;

   localparam int W  = 4;
   localparam int RW = 2 * W;
   localparam int M  = 1 << RW;   // result modulus
   localparam int HM = 1 << W;    // operand modulus

   logic          clk = 1'b0;
   logic          rst_n;
   logic [W-1:0]  A;
   logic [W-1:0]  B;
   logic [2:0]    OpCode;
   logic          in_valid;
   logic [RW-1:0] Result;
   logic          out_valid;
   logic          div_zero;
`ifdef ALU_FLAGS_EN
   logic          zero;
   logic          carry;
   logic          neg;
`endif

   int n_tests = 0;
   int n_fail  = 0;

   // model state: registered values the DUT should hold
   int unsigned exp_res = 0;
   bit          exp_ov  = 1'b0;
   bit          exp_dz  = 1'b0;
   bit          exp_zf  = 1'b0;
   bit          exp_cf  = 1'b0;
   bit          exp_nf  = 1'b0;

   alu #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .A         (A),
      .B         (B),
      .OpCode    (OpCode),
      .in_valid  (in_valid),
      .Result    (Result),
      .out_valid (out_valid),
`ifdef ALU_FLAGS_EN
      .zero      (zero),
      .carry     (carry),
      .neg       (neg),
`endif
      .div_zero  (div_zero)
   );

   always #5 clk = ~clk;

   // behavioural reference: straight integer arithmetic from the opcode table
   function automatic int unsigned ref_result(input int unsigned a, input int unsigned b,
                                              input int unsigned op);
      case (op % 8)
         0: return a + b;
         1: return (a + M - b) % M;
         2: return a * b;
         3: return (b == 0) ? (M - 1) : ((a % b) * HM + (a / b));
         4: return a & b;
         5: return a | b;
         6: return a ^ b;
         default: return (HM - 1) - a;
      endcase
   endfunction

   task automatic check(input string tag, input int unsigned obs, input int unsigned exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // drive one cycle, update the model, then compare every output after the edge
   task automatic step(input int unsigned a, input int unsigned b, input int unsigned op,
                       input bit v);
      int unsigned opl;
      opl      = op % 8;
      A        = a[W-1:0];
      B        = b[W-1:0];
      OpCode   = op[2:0];
      in_valid = v;
      exp_ov   = v;
      if (v) begin
         exp_res = ref_result(a, b, op);
         exp_dz  = (opl == 3) && (b == 0);
         exp_zf  = (exp_res == 0);
         exp_cf  = ((opl == 0) && (a + b >= HM)) || ((opl == 1) && (a < b));
         exp_nf  = (exp_res >= M / 2);
      end
      @(posedge clk);
      #1;
      check("result",    Result,    exp_res);
      check("out_valid", out_valid, exp_ov);
      check("div_zero",  div_zero,  exp_dz);
`ifdef ALU_FLAGS_EN
      check("zero",  zero,  exp_zf);
      check("carry", carry, exp_cf);
      check("neg",   neg,   exp_nf);
`endif
   endtask

   initial begin
      // reset held for two edges while in_valid is high
      rst_n = 1'b0; A = 4'd5; B = 4'd3; OpCode = 3'd2; in_valid = 1'b1;
      @(posedge clk); @(posedge clk); #1;
      check("rst_result",    Result,    0);
      check("rst_out_valid", out_valid, 0);
      check("rst_div_zero",  div_zero,  0);
      rst_n = 1'b1;

      // arithmetic with A=5, B=3
      step(5, 3, 0, 1); check("t2_add", Result, 'h08);
      step(5, 3, 1, 1); check("t2_sub", Result, 'h02);
      step(5, 3, 2, 1); check("t2_mul", Result, 'h0F);
      step(5, 3, 3, 1); check("t2_div", Result, 'h21); check("t2_dz", div_zero, 0);

      // logic and wrap-around
      step(4, 3, 4, 1); check("t3_and",  Result, 'h00);
      step(7, 3, 5, 1); check("t3_or",   Result, 'h07);
      step(7, 3, 6, 1); check("t3_xor",  Result, 'h04);
      step(5, 9, 7, 1); check("t3_not",  Result, 'h0A);
      step(3, 5, 1, 1); check("t3_wrap", Result, 'hFE);

      // divide by zero, then cleared by the next op
      step(9, 0, 3, 1); check("t4_dz_res", Result, 'hFF); check("t4_dz", div_zero, 1);
      step(9, 0, 0, 1); check("t4_dz_clr", div_zero, 0);

      // wide opcode literal truncates: 8 -> ADD, 11 -> DIV
      step(6, 2, 8, 1);  check("trunc_add", Result, 'h08);
      step(7, 2, 11, 1); check("trunc_div", Result, 'h13);

      // back-to-back stream, then idle: Result must hold the XOR value
      for (int op = 0; op < 7; op++) step(7, 3, op, 1);
      step(1, 1, 0, 0); check("t5_hold",    Result, 'h04); check("t5_ov", out_valid, 0);
      step(2, 2, 2, 0); check("t5_hold2",   Result, 'h04);

`ifdef ALU_FLAGS_EN
      step(15, 1, 0, 1); check("t6_res", Result, 'h10); check("t6_carry", carry, 1);
      step(3, 5, 1, 1);  check("t6_borrow", carry, 1);  check("t6_neg", neg, 1);
      step(4, 3, 4, 1);  check("t6_zero", zero, 1);
`endif

      // randomized operations with occasional idle cycles
      for (int i = 0; i < 300; i++) begin
         step($urandom_range(0, HM - 1), $urandom_range(0, HM - 1),
              $urandom_range(0, 15), ($urandom_range(0, 3) != 0));
      end

      // reset in the middle of traffic clears everything again
      rst_n = 1'b0; in_valid = 1'b1;
      @(posedge clk); #1;
      check("rst2_result",    Result,    0);
      check("rst2_out_valid", out_valid, 0);
      check("rst2_div_zero",  div_zero,  0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
